// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Optional zero flag Z is built when SERIAL_ADD_SUB_ZERO_EN is defined.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             M,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
`ifdef SERIAL_ADD_SUB_ZERO_EN
    output logic             Z,
`endif
    output logic             V
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, co_q, co_d, v_q, v_d;
    logic             sbit, cout;
`ifdef SERIAL_ADD_SUB_ZERO_EN
    logic             acc_q, acc_d, z_q, z_d;
`endif

    // The single full-adder cell.
    assign sbit = a_q[0] ^ b_q[0] ^ c_q;
    assign cout = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        v_d     = v_q;
`ifdef SERIAL_ADD_SUB_ZERO_EN
        acc_d   = acc_q;
        z_d     = z_q;
`endif
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract as A + ~B + 1: invert B and preset the carry.
                    a_d     = A;
                    b_d     = B ^ {WIDTH{M}};
                    c_d     = M;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_ZERO_EN
                    acc_d   = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d   = {sbit, r_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = cout;
                cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_ADD_SUB_ZERO_EN
                acc_d = acc_q | sbit;
`endif
                if (cnt_q == LAST) begin
                    // c_q is the carry into the MSB on this last bit.
                    s_d     = r_d;
                    co_d    = cout;
                    v_d     = c_q ^ cout;
`ifdef SERIAL_ADD_SUB_ZERO_EN
                    z_d     = ~(acc_q | sbit);
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
            c_q   <= 1'b0;
            co_q  <= 1'b0;
            v_q   <= 1'b0;
`ifdef SERIAL_ADD_SUB_ZERO_EN
            acc_q <= 1'b0;
            z_q   <= 1'b0;
`endif
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            r_q   <= r_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
            c_q   <= c_d;
            co_q  <= co_d;
            v_q   <= v_d;
`ifdef SERIAL_ADD_SUB_ZERO_EN
            acc_q <= acc_d;
            z_q   <= z_d;
`endif
        end
    end

    assign S  = s_q;
    assign Co = co_q;
    assign V  = v_q;
`ifdef SERIAL_ADD_SUB_ZERO_EN
    assign Z  = z_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: stimulus pushes model results, a monitor checks each done.
module tb_serial_add_sub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         M = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Co, V;
    logic [W-1:0] S;
`ifdef SERIAL_ADD_SUB_ZERO_EN
    logic         Z;
`endif

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co),
`ifdef SERIAL_ADD_SUB_ZERO_EN
        .Z     (Z),
`endif
        .V     (V)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         v;
        logic         z;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           vecs = 0;
    int           errs = 0;
    int           cyc  = 0;
    logic [W-1:0] hold_s = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        vecs++;
        errs++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        int ua, ub, ur, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = m ? ua - ub : ua + ub;
        sr = m ? sa - sb : sa + sb;
        e.s   = W'(ur & ((1 << W) - 1));
        e.co  = m ? (ua >= ub) : (ur >= (1 << W));
        e.v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.z   = (e.s == '0);
        e.acc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("S", S, e.s);
                chk("Co", Co, e.co);
                chk("V", V, e.v);
`ifdef SERIAL_ADD_SUB_ZERO_EN
                chk("Z", Z, e.z);
`endif
                chk("latency", cyc - e.acc, W);
                chk("busy_in_done", busy, 1'b1);
                hold_s = e.s;
            end
        end else if (rst_n === 1'b1 && busy === 1'b1) begin
            chk("S_hold_during_run", S, hold_s);
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("idle_timeout");
        A = a;
        B = b;
        M = m;
        start = 1'b1;
        e = model(a, b, m);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        M = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) fail_now("drain_timeout");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_S", S, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_S", S, 8'h00);
        chk("idle_Co", Co, 1'b0);
        chk("idle_V", V, 1'b0);
`ifdef SERIAL_ADD_SUB_ZERO_EN
        chk("idle_Z", Z, 1'b0);
`endif

        do_op(8'h05, 8'h03, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0);
        do_op(8'h03, 8'h05, 1'b1);
        do_op(8'h80, 8'h01, 1'b1);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'h80, 8'h80, 1'b0);
        drain();

        // Start pulses while busy must be dropped, not queued.
        do_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        A = 8'hAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
        repeat (12) @(negedge clk);

        // Start held high: second accept WIDTH+2 edges after the first.
        begin
            exp_t e1, e2;
            @(negedge clk);
            A = 8'h3C;
            B = 8'h4D;
            M = 1'b1;
            start = 1'b1;
            e1 = model(8'h3C, 8'h4D, 1'b1);
            e1.acc = cyc + 1;
            e2 = e1;
            e2.acc = cyc + 1 + W + 2;
            q.push_back(e1);
            q.push_back(e2);
            repeat (W + 3) @(negedge clk);
            start = 1'b0;
            drain();
        end

        // Abort with reset mid-RUN.
        do_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_S", S, 8'h00);
        chk("abort_Co", Co, 1'b0);
        chk("abort_V", V, 1'b0);
        q.delete();
        hold_s = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0);
        drain();

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            int sel;
            sel = $urandom_range(0, 7);
            ra = (sel == 0) ? 8'h80 : (sel == 1) ? 8'h7F : W'($urandom);
            rb = (sel == 2) ? 8'hFF : (sel == 3) ? ra : W'($urandom);
            do_op(ra, rb, 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
